ir_sweep_seq: RTL and testbench

- Sequences the external 8-channel A2D to sweep all IR line sensors: enables the emitters, waits for them to settle, then converts the 8 channels in a fixed order.
- Buffers all 8 results and publishes them together as one coherent set with a single IR_vld pulse.
- Sits between the A2D SPI interface and the error-compute block, which consumes IR_R0..IR_R3, IR_L0..IR_L3 and IR_vld.

---
 rtl/ir_sweep_seq_pkg.sv | 25 ++
 rtl/ir_sweep_seq_if.sv | 13 +
 rtl/ir_sweep.sv | 3 +
 rtl/ir_sweep_seq_shadow_bank.sv | 37 +++
 rtl/ir_sweep_seq.sv | 162 ++++++++++++++++
 tb/tb_ir_sweep_seq.sv | 299 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ir_sweep_seq_pkg.sv
// Shared types and constants for the IR line-sensor sweep sequencer.
// The slot table fixes both the A2D channel and the published destination of each reading.
package ir_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int A2D_W     = 12;
  localparam int SLOT_W    = 3;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [2:0]        chnl_t;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    REQ,
    WAIT,
    PUB
  } state_e;

  // Slot order R0, L0, R1, L1, R2, L2, R3, L3 mapped to A2D channels.
  localparam chnl_t SLOT_CHNL [NUM_SLOTS] = '{
    3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7, 3'd6, 3'd5
  };

endpackage

// File: rtl/ir_sweep_seq_if.sv
// Conversion handshake between the sweep sequencer (master) and the A2D SPI block (slave).
interface ir_sweep_seq_if;
  import ir_pkg::*;

  logic              strt_cnv;
  chnl_t             chnnl;
  logic              cnv_cmplt;
  logic [A2D_W-1:0]  res;

  modport master (output strt_cnv, chnnl, input  cnv_cmplt, res);
  modport slave  (input  strt_cnv, chnnl, output cnv_cmplt, res);

endinterface

// File: rtl/ir_sweep.sv
// Empty guard module; the sweep sequencer itself is in ir_sweep_seq.sv.
module ir_sweep_unused_guard;
endmodule

// File: rtl/ir_sweep_seq_shadow_bank.sv
// Eight shadow registers filled one slot at a time, plus the published copy that
// only changes on the publish strobe so consumers never see a partial sweep.
module ir_shadow_bank
  import ir_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  slot_t            wr_slot,
  input  logic [A2D_W-1:0] wr_data,
  input  logic             pub_ld,
  output logic [A2D_W-1:0] pub [NUM_SLOTS]
);

  logic [A2D_W-1:0] shadow [NUM_SLOTS];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the bank is small and its reset value is visible, so it is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) shadow[i] <= '0;
    end else if (wr_en) begin
      shadow[wr_slot] <= wr_data;
    end
  end

  // The last slot is written on the same edge as the publish, so forward it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) pub[i] <= '0;
    end else if (pub_ld) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        pub[i] <= (wr_en && (wr_slot == SLOT_W'(i))) ? wr_data : shadow[i];
    end
  end

endmodule

// File: rtl/ir_sweep_seq.sv
// IR sensor sweep sequencer: powers the emitters, lets them settle, converts the eight
// line sensors in slot order with timeout retry, and publishes the set with one IR_vld.
module ir_sweep_seq
  import ir_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4096,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  ir_sweep_seq_if.master     a2d,
  output logic               IR_en,
  output logic [A2D_W-1:0]   IR_R0,
  output logic [A2D_W-1:0]   IR_R1,
  output logic [A2D_W-1:0]   IR_R2,
  output logic [A2D_W-1:0]   IR_R3,
  output logic [A2D_W-1:0]   IR_L0,
  output logic [A2D_W-1:0]   IR_L1,
  output logic [A2D_W-1:0]   IR_L2,
  output logic [A2D_W-1:0]   IR_L3,
  output logic               IR_vld,
  output logic               busy
);

  localparam int SW = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam slot_t         SLOT_LAST    = SLOT_W'(NUM_SLOTS - 1);

  state_e          state, state_d;
  logic [SW-1:0]   settle_cnt, settle_d;
  logic [TW-1:0]   tmo_cnt, tmo_d;
  slot_t           slot, slot_d, slot_inc;
  logic            strt_q, strt_d;
  chnl_t           chnnl_q, chnnl_d;
  logic            ir_en_q, ir_en_d;
  logic            ir_vld_q, busy_q;
  logic            wr_en, pub_ld;
  logic [A2D_W-1:0] pub [NUM_SLOTS];

  assign slot_inc = slot + SLOT_W'(1);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state;
    settle_d = settle_cnt;
    tmo_d    = tmo_cnt;
    slot_d   = slot;
    strt_d   = 1'b0;
    chnnl_d  = chnnl_q;
    ir_en_d  = ir_en_q;
    wr_en    = 1'b0;
    pub_ld   = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_d  = SETTLE;
          ir_en_d  = 1'b1;
          settle_d = '0;
          slot_d   = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_d = REQ;
          strt_d  = 1'b1;
          chnnl_d = SLOT_CHNL[slot];
        end else begin
          settle_d = settle_cnt + 1'b1;
        end
      end
      REQ: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        // A completion on the timeout cycle wins: the result is taken, no retry.
        if (a2d.cnv_cmplt) begin
          wr_en = 1'b1;
          if (slot == SLOT_LAST) begin
            state_d = PUB;
            pub_ld  = 1'b1;
          end else begin
            state_d = REQ;
            slot_d  = slot_inc;
            strt_d  = 1'b1;
            chnnl_d = SLOT_CHNL[slot_inc];
          end
        end else if (tmo_cnt == TIMEOUT_LAST) begin
          state_d = REQ;
          strt_d  = 1'b1;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      PUB: begin
        if (go) begin
          state_d = REQ;
          slot_d  = '0;
          strt_d  = 1'b1;
          chnnl_d = SLOT_CHNL[0];
        end else begin
          state_d = IDLE;
          ir_en_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      slot       <= '0;
      strt_q     <= 1'b0;
      chnnl_q    <= '0;
      ir_en_q    <= 1'b0;
      ir_vld_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      settle_cnt <= settle_d;
      tmo_cnt    <= tmo_d;
      slot       <= slot_d;
      strt_q     <= strt_d;
      chnnl_q    <= chnnl_d;
      ir_en_q    <= ir_en_d;
      ir_vld_q   <= pub_ld;
      busy_q     <= (state_d != IDLE);
    end
  end

  ir_shadow_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_slot (slot),
    .wr_data (a2d.res),
    .pub_ld  (pub_ld),
    .pub     (pub)
  );

  assign a2d.strt_cnv = strt_q;
  assign a2d.chnnl    = chnnl_q;
  assign IR_en        = ir_en_q;
  assign IR_vld       = ir_vld_q;
  assign busy         = busy_q;

  assign IR_R0 = pub[0];
  assign IR_L0 = pub[1];
  assign IR_R1 = pub[2];
  assign IR_L1 = pub[3];
  assign IR_R2 = pub[4];
  assign IR_L2 = pub[5];
  assign IR_R3 = pub[6];
  assign IR_L3 = pub[7];

endmodule

// File: tb/tb_ir_sweep_seq.sv
// Directed bench for ir_sweep_seq with a small A2D responder (latency 3, optional
// dropped, slow and spurious responses) and hand-computed expected readings.
module tb_ir_sweep_seq;
  import ir_pkg::*;

  logic clk, rst_n, go;
  logic IR_en, IR_vld, busy;
  logic [11:0] IR_R0, IR_R1, IR_R2, IR_R3, IR_L0, IR_L1, IR_L2, IR_L3;
  logic [11:0] ir_out [8];

  ir_sweep_seq_if a2d ();

  ir_sweep_seq #(.SETTLE_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .a2d(a2d),
    .IR_en(IR_en),
    .IR_R0(IR_R0), .IR_R1(IR_R1), .IR_R2(IR_R2), .IR_R3(IR_R3),
    .IR_L0(IR_L0), .IR_L1(IR_L1), .IR_L2(IR_L2), .IR_L3(IR_L3),
    .IR_vld(IR_vld), .busy(busy)
  );

  assign ir_out[0] = IR_R0;
  assign ir_out[1] = IR_L0;
  assign ir_out[2] = IR_R1;
  assign ir_out[3] = IR_L1;
  assign ir_out[4] = IR_R2;
  assign ir_out[5] = IR_L2;
  assign ir_out[6] = IR_R3;
  assign ir_out[7] = IR_L3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  chnl;       // channel the slot must request
    logic [11:0] basic_val;  // published value when the A2D returns 0x100+chnnl
  } slot_vec_t;
  slot_vec_t tbl [8];

  int checks = 0;
  int errors = 0;

  // A2D responder controls, written only by the main test.
  logic [11:0] res_base = 12'h100;
  bit drop_ch4 = 0;
  bit glitch   = 0;
  bit slow_ch2 = 0;

  // Monitor: strt_cnv history with cycle stamps, IR_vld count.
  int cyc = 0;
  int vld_cnt = 0;
  logic [2:0] strt_ch [$];
  int strt_cyc [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (a2d.strt_cnv) begin
      strt_ch.push_back(a2d.chnnl);
      strt_cyc.push_back(cyc);
    end
    if (IR_vld) vld_cnt <= vld_cnt + 1;
  end

  // A2D responder: counts down from each strt_cnv and pulses cnv_cmplt.
  initial begin
    int cnt;
    logic [2:0] cur_ch;
    bit drop_done;
    cnt = 0; cur_ch = '0; drop_done = 0;
    a2d.cnv_cmplt = 1'b0;
    a2d.res = '0;
    forever begin
      @(negedge clk);
      a2d.cnv_cmplt = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          a2d.cnv_cmplt = 1'b1;
          a2d.res = res_base + 12'(cur_ch);
        end
      end
      if (a2d.strt_cnv) begin
        if (glitch) begin
          a2d.cnv_cmplt = 1'b1;
          a2d.res = 12'hBAD;
        end
        if (drop_ch4 && !drop_done && a2d.chnnl == 3'd4) begin
          drop_done = 1;
        end else begin
          cur_ch = a2d.chnnl;
          cnt = (slow_ch2 && a2d.chnnl == 3'd2) ? 16 : 3;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_pub(input string tag, input logic [11:0] base);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_pub%0d", tag, i), 32'(ir_out[i]),
            32'(base + tbl[i].basic_val - 12'h100));
  endtask

  task automatic check_chseq(input string tag, input int start);
    check({tag, "_strt_count"}, 32'(strt_ch.size() - start), 32'd8);
    if (strt_ch.size() >= start + 8)
      for (int i = 0; i < 8; i++)
        check($sformatf("%s_chnnl%0d", tag, i), 32'(strt_ch[start + i]), 32'(tbl[i].chnl));
  endtask

  // Called right after the negedge where go (or rst_n release) took effect.
  task automatic check_startup(input string tag);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_ir_en_edge1"}, 32'(IR_en), 32'd1);
        check({tag, "_busy_edge1"}, 32'(busy), 32'd1);
      end
      if (k == 8) check({tag, "_no_strt_edge8"}, 32'(a2d.strt_cnv), 32'd0);
      if (k == 9) begin
        check({tag, "_strt_edge9"}, 32'(a2d.strt_cnv), 32'd1);
        check({tag, "_chnnl_edge9"}, 32'(a2d.chnnl), 32'd1);
      end
    end
  endtask

  task automatic wait_vld(input string tag, input int budget);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (IR_vld) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_vld_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start, vbase, en_low, bad;
    bit seen, dropped;
    logic [11:0] base;
    logic [2:0] retry_seq [9];

    tbl[0] = '{3'd1, 12'h101};
    tbl[1] = '{3'd0, 12'h100};
    tbl[2] = '{3'd4, 12'h104};
    tbl[3] = '{3'd2, 12'h102};
    tbl[4] = '{3'd3, 12'h103};
    tbl[5] = '{3'd7, 12'h107};
    tbl[6] = '{3'd6, 12'h106};
    tbl[7] = '{3'd5, 12'h105};
    retry_seq = '{3'd1, 3'd0, 3'd4, 3'd4, 3'd2, 3'd3, 3'd7, 3'd6, 3'd5};

    // Reset state.
    rst_n = 1'b0;
    go = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ir_en", 32'(IR_en), 32'd0);
    check("rst_strt", 32'(a2d.strt_cnv), 32'd0);
    check("rst_chnnl", 32'(a2d.chnnl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_vld", 32'(IR_vld), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_pub%0d", i), 32'(ir_out[i]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sweep: go pulses, drops before the sweep ends.
    start = strt_ch.size();
    vbase = vld_cnt;
    res_base = 12'h100;
    go = 1'b1;
    check_startup("basic");
    go = 1'b0;
    wait_vld("basic", 200);
    check_pub("basic", 12'h100);
    check_chseq("basic", start);
    @(negedge clk);
    check("basic_ir_en_off", 32'(IR_en), 32'd0);
    check("basic_busy_off", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("basic_vld_count", 32'(vld_cnt - vbase), 32'd1);

    // Continuous run: three sweeps, coherency on sweep 2, go drops at slot 4 of sweep 3.
    vbase = vld_cnt;
    en_low = 0;
    dropped = 0;
    res_base = 12'h200;
    go = 1'b1;
    for (int sw = 0; sw < 3; sw++) begin
      base = 12'h200 + 12'(sw * 12'h100);
      seen = 0;
      bad = 0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (k > 0 && !IR_en) en_low++;
        if (sw == 2 && !dropped && a2d.strt_cnv && a2d.chnnl == 3'd3) begin
          go = 1'b0;
          dropped = 1;
        end
        if (IR_vld) begin
          seen = 1;
          break;
        end
        if (sw == 1)
          for (int i = 0; i < 8; i++)
            if (ir_out[i] !== 12'(12'h200 + tbl[i].basic_val - 12'h100)) bad++;
      end
      check($sformatf("cont%0d_vld_seen", sw), 32'(seen), 32'd1);
      check_pub($sformatf("cont%0d", sw), base);
      if (sw == 1) check("cont1_coherent", 32'(bad), 32'd0);
      res_base = base + 12'h100;
      if (sw < 2) begin
        @(negedge clk);
        check($sformatf("cont%0d_next_strt", sw), 32'(a2d.strt_cnv), 32'd1);
        check($sformatf("cont%0d_next_chnnl", sw), 32'(a2d.chnnl), 32'd1);
      end
    end
    check("cont_ir_en_held", 32'(en_low), 32'd0);
    check("cont_go_dropped", 32'(dropped), 32'd1);
    @(negedge clk);
    check("cont_ir_en_off", 32'(IR_en), 32'd0);
    check("cont_busy_off", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("cont_vld_count", 32'(vld_cnt - vbase), 32'd3);

    // Timeout retry on slot 2, completion on the timeout cycle for slot 3,
    // spurious cnv_cmplt in every REQ cycle.
    start = strt_ch.size();
    res_base = 12'h500;
    drop_ch4 = 1;
    glitch = 1;
    slow_ch2 = 1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_vld("retry", 400);
    glitch = 0;
    slow_ch2 = 0;
    check("retry_strt_count", 32'(strt_ch.size() - start), 32'd9);
    if (strt_ch.size() >= start + 9) begin
      for (int i = 0; i < 9; i++)
        check($sformatf("retry_chnnl%0d", i), 32'(strt_ch[start + i]), 32'(retry_seq[i]));
      check("retry_interval", 32'(strt_cyc[start + 3] - strt_cyc[start + 2]), 32'd17);
    end
    check_pub("retry", 12'h500);
    @(negedge clk);

    // Asynchronous reset at slot 5, then restart with go held high.
    vbase = vld_cnt;
    res_base = 12'h600;
    go = 1'b1;
    seen = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (a2d.strt_cnv && a2d.chnnl == 3'd7) begin
        seen = 1;
        break;
      end
    end
    check("rstmid_slot5_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_strt", 32'(a2d.strt_cnv), 32'd0);
    check("rstmid_ir_en", 32'(IR_en), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_chnnl", 32'(a2d.chnnl), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("rstmid_pub%0d", i), 32'(ir_out[i]), 32'd0);
    repeat (3) @(negedge clk);
    check("rstmid_no_vld", 32'(vld_cnt - vbase), 32'd0);
    start = strt_ch.size();
    rst_n = 1'b1;
    check_startup("restart");
    go = 1'b0;
    wait_vld("restart", 200);
    check_pub("restart", 12'h600);
    check_chseq("restart", start);
    @(negedge clk);
    check("restart_ir_en_off", 32'(IR_en), 32'd0);
    check("restart_vld_count", 32'(vld_cnt - vbase), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
